stream_arb_mux: RTL

STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

---
 rtl/stream_arb_mux_if.sv | 26 ++
 rtl/stream_arb_mux.sv | 107 ++++++++++
 2 files changed

// File: rtl/stream_arb_mux_if.sv
// Stream bundle for the arbitrating mux: N input streams in, one output stream out.
// The mux owns the slave view; the upstream/downstream environment owns the master view.
interface stream_arb_mux_if #(
   parameter int INPUTS = 4,
   parameter int DWIDTH = 8
);
   logic [INPUTS*DWIDTH-1:0]   i_dat;
   logic [INPUTS-1:0]          i_val;
   logic [INPUTS-1:0]          i_eop;
   logic [INPUTS-1:0]          i_rdy;
   logic [DWIDTH-1:0]          o_dat;
   logic                       o_val;
   logic                       o_eop;
   logic                       o_rdy;
   logic [$clog2(INPUTS)-1:0]  o_num;

   modport slave (
      input  i_dat, i_val, i_eop, o_rdy,
      output i_rdy, o_dat, o_val, o_eop, o_num
   );

   modport master (
      output i_dat, i_val, i_eop, o_rdy,
      input  i_rdy, o_dat, o_val, o_eop, o_num
   );
endinterface

// File: rtl/stream_arb_mux.sv
// Packet-locked N:1 stream mux with round-robin or fixed-priority arbitration
// and a single registered output stage.
module stream_arb_mux #(
   parameter int    INPUTS = 4,
   parameter int    DWIDTH = 8,
   parameter string SCHEME = "RR"
) (
   input logic              clk,
   input logic              reset_n,
   stream_arb_mux_if.slave  bus
);
   localparam int NW = $clog2(INPUTS);
   localparam bit IsFp = (SCHEME == "FP");
   localparam logic [NW-1:0] LastIdx = NW'(INPUTS - 1);

   typedef enum logic {StIdle, StLock} state_e;

   state_e              r_state;
   logic [NW-1:0]       r_sel;
   logic [NW-1:0]       r_ptr;
   logic [DWIDTH-1:0]   r_dat;
   logic                r_val;
   logic                r_eop;
   logic [NW-1:0]       r_num;

   logic [NW-1:0]       w_win;
   logic [NW-1:0]       w_idx;
   logic                w_any;
   logic                w_open;
   logic                w_xfer;
   logic                w_eop;
   logic [DWIDTH-1:0]   w_dat;

   // Scan from the pointer (RR) or from 0 (FP); first requester wins.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      w_idx = '0;
      for (int i = 0; i < INPUTS; i++) begin
         if (IsFp) begin
            w_idx = NW'(i);
         end else begin
            w_idx = NW'((int'(r_ptr) + i) % INPUTS);
         end
         if (!w_any && bus.i_val[w_idx]) begin
            w_win = w_idx;
            w_any = 1'b1;
         end
      end
   end

   // Output register can take a word when empty or draining this cycle.
   assign w_open = (r_state == StLock) && (!r_val || bus.o_rdy);
   assign w_dat  = bus.i_dat[int'(r_sel)*DWIDTH +: DWIDTH];
   assign w_eop  = bus.i_eop[r_sel];
   assign w_xfer = w_open && bus.i_val[r_sel];

   always_comb begin
      bus.i_rdy = '0;
      if (w_open) begin
         bus.i_rdy[r_sel] = 1'b1;
      end
   end

   assign bus.o_dat = r_dat;
   assign bus.o_val = r_val;
   assign bus.o_eop = r_eop;
   assign bus.o_num = r_num;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StIdle;
         r_sel   <= '0;
         r_ptr   <= '0;
         r_dat   <= '0;
         r_val   <= 1'b0;
         r_eop   <= 1'b0;
         r_num   <= '0;
      end else begin
         if (w_xfer) begin
            r_dat <= w_dat;
            r_eop <= w_eop;
            r_num <= r_sel;
            r_val <= 1'b1;
         end else if (bus.o_rdy) begin
            r_val <= 1'b0;
         end

         unique case (r_state)
            StIdle: begin
               if (w_any) begin
                  r_sel   <= w_win;
                  r_state <= StLock;
               end
            end
            StLock: begin
               if (w_xfer && w_eop) begin
                  r_state <= StIdle;
                  if (!IsFp) begin
                     r_ptr <= (r_sel == LastIdx) ? '0 : r_sel + NW'(1);
                  end
               end
            end
         endcase
      end
   end
endmodule
